spi_tx_arbiter: RTL
===================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning word FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter GAP, default 2, meaning idle cycles between consecutive serializer frames (0..15).
REQ-003 SHALL have port clk_i  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a_valid_i  input  1  requester A word valid.
REQ-006 SHALL have port a_data_i  input  32  requester A word.
REQ-007 SHALL have port a_ready_o  output  1  requester A word accepted this cycle.
REQ-008 SHALL have port b_valid_i  input  1  requester B word valid.
REQ-009 SHALL have port b_data_i  input  32  requester B word.
REQ-010 SHALL have port b_ready_o  output  1  requester B word accepted this cycle.
REQ-011 SHALL have port tx_req_o  output  1  one-cycle start pulse to 32-bit SPI serializer.
REQ-012 SHALL have port tx_data_o  output  32  word to serializer, MSB sent first.
REQ-013 SHALL have port tx_cs_i  input  1  serializer chip-select; low = frame in progress, high = idle.
REQ-014 SHALL have port busy_o  output  1  FSM not IDLE or FIFO not empty.
REQ-015 SHALL have port fifo_count_o  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port words_sent_o  output  16  completed-frame counter.
REQ-017 SHALL have port err_o  output  1  sticky start-timeout flag.

Function
REQ-018 SHALL drive a_ready_o = !full & (!b_valid_i | prio==A) and b_ready_o = !full & (!a_valid_i | prio==B), combinationally from registered full/prio.
REQ-019 SHALL transfer a word when valid & ready; at most one transfer per cycle; prio becomes the other requester after each transfer, unchanged otherwise.
REQ-020 SHALL push the transferred word into the FIFO tail; push blocked when full even if a pop occurs the same cycle.
REQ-021 SHALL implement FSM states IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP_WAIT.
REQ-022 IDLE: if FIFO not empty -> ISSUE, register head into tx_data_o, pop FIFO; else stay.
REQ-023 ISSUE: assert tx_req_o for exactly this one cycle, clear timeout counter -> WAIT_START.
REQ-024 WAIT_START: tx_cs_i low -> WAIT_DONE; else increment 3-bit timeout counter; at count 7 with tx_cs_i still high set err_o, drop word, -> GAP_WAIT.
REQ-025 WAIT_DONE: tx_cs_i high -> GAP_WAIT, increment words_sent_o (wraps 0xFFFF->0x0000); else stay.
REQ-026 GAP_WAIT: load counter with GAP on entry; -> IDLE after GAP cycles in state (GAP=0: one cycle in state, then IDLE).
REQ-027 SHALL hold tx_data_o stable from IDLE exit until next IDLE->ISSUE transition.
REQ-028 SHALL keep tx_req_o low in every state except ISSUE.
REQ-029 err_o SHALL remain set until reset; FSM continues with next word.
REQ-030 A word pushed to an empty FIFO SHALL reach tx_req_o no earlier than 2 cycles after acceptance (push, IDLE pop, ISSUE).

Reset
REQ-031 On rst_ni low, asynchronously: FSM IDLE, FIFO empty, prio=A, tx_req_o=0, tx_data_o=0, err_o=0, words_sent_o=0, counters 0.
REQ-032 Reset mid-frame SHALL discard FIFO contents and the in-flight word; no tx_req_o until new words arrive after release.

Verification
REQ-033 A sends 0xA5A5_0001 into empty idle block, serializer model drops cs 2 cycles after req, holds 64 cycles -> tx_req_o pulses once, tx_data_o=0xA5A5_0001, words_sent_o=1, busy_o low after GAP+1 cycles.
REQ-034 A and B valid continuously with distinct words, first with prio=A -> FIFO order A0,B0,A1,B1; serialized in that order.
REQ-035 Fill FIFO with 4 words while serializer busy -> fifo_count_o=4, both ready low; after next pop exactly one new word accepted.
REQ-036 Serializer model never drops cs -> err_o=1 after 8 WAIT_START cycles, words_sent_o unchanged, next word issued.
REQ-037 Preload words_sent_o to 0xFFFF via 65535 frames (or force) -> next frame yields 0x0000.
REQ-038 Assert rst_ni low during WAIT_DONE with 3 words queued -> all outputs at reset values, fifo_count_o=0, no tx_req_o after release.

Source files
------------

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter
//   Two-requester word arbiter feeding a 32-bit SPI serializer through a
//   small word FIFO. Requesters A and B are granted alternately when both
//   are valid. A frame-sequencing FSM pops one word per frame, pulses
//   tx_req_o, waits for the serializer chip-select to go low (start) and
//   back high (done), then idles for GAP cycles. If the start does not
//   come within 8 cycles, the word is dropped and err_o is set sticky.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   a_valid_i/a_data_i/a_ready_o   requester A word handshake
//   b_valid_i/b_data_i/b_ready_o   requester B word handshake
//   tx_req_o, tx_data_o      one-cycle start pulse and word to serializer
//   tx_cs_i                  serializer chip-select (low = frame running)
//   busy_o                   FSM active or FIFO holding words
//   fifo_count_o             FIFO occupancy
//   words_sent_o             completed-frame counter (wrapping)
//   err_o                    sticky start-timeout flag
module spi_tx_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       a_valid_i,
    input  logic [31:0]                a_data_i,
    output logic                       a_ready_o,
    input  logic                       b_valid_i,
    input  logic [31:0]                b_data_i,
    output logic                       b_ready_o,
    output logic                       tx_req_o,
    output logic [31:0]                tx_data_o,
    input  logic                       tx_cs_i,
    output logic                       busy_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o,
    output logic [15:0]                words_sent_o,
    output logic                       err_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_GAP_WAIT
    } state_t;

    state_t          r_state, w_state_nxt;

    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_prio_b;      // 0: A wins a tie, 1: B wins a tie
    logic [31:0]     r_tx_data;
    logic [2:0]      r_to_cnt;
    logic [3:0]      r_gap_cnt;
    logic [15:0]     r_words_sent;
    logic            r_err;

    logic            w_full, w_empty;
    logic            w_a_xfer, w_b_xfer, w_push, w_pop;
    logic [31:0]     w_push_data;
    logic            w_to_clr, w_to_inc, w_err_set, w_sent_inc, w_gap_load, w_gap_dec;

    // ---------------------------------------------------------------- arbiter
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    assign a_ready_o = !w_full && (!b_valid_i || !r_prio_b);
    assign b_ready_o = !w_full && (!a_valid_i ||  r_prio_b);

    // Ready terms are mutually exclusive when both are valid, so at most
    // one transfer happens per cycle.
    assign w_a_xfer    = a_valid_i && a_ready_o;
    assign w_b_xfer    = b_valid_i && b_ready_o;
    assign w_push      = w_a_xfer || w_b_xfer;
    assign w_push_data = w_a_xfer ? a_data_i : b_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio_b <= 1'b0;
        end else if (w_a_xfer) begin
            r_prio_b <= 1'b1;
        end else if (w_b_xfer) begin
            r_prio_b <= 1'b0;
        end
    end

    // ------------------------------------------------------------------- FIFO
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_to_clr    = 1'b0;
        w_to_inc    = 1'b0;
        w_err_set   = 1'b0;
        w_sent_inc  = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;
        tx_req_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_req_o    = 1'b1;
                w_to_clr    = 1'b1;
                w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!tx_cs_i) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (r_to_cnt == 3'd7) begin
                    // eighth cycle without a start: give up on this word
                    w_err_set   = 1'b1;
                    w_gap_load  = 1'b1;
                    w_state_nxt = S_GAP_WAIT;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (tx_cs_i) begin
                    w_sent_inc  = 1'b1;
                    w_gap_load  = 1'b1;
                    w_state_nxt = S_GAP_WAIT;
                end
            end
            S_GAP_WAIT: begin
                // GAP of 0 or 1 both spend a single cycle here
                if (r_gap_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_data    <= '0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_words_sent <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_to_inc) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_gap_load) begin
                r_gap_cnt <= 4'(GAP);
            end else if (w_gap_dec) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            if (w_sent_inc) begin
                r_words_sent <= r_words_sent + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tx_data_o    = r_tx_data;
    assign words_sent_o = r_words_sent;
    assign err_o        = r_err;
    assign fifo_count_o = r_count;
    assign busy_o       = (r_state != S_IDLE) || !w_empty;

endmodule
